// File: rtl/fsm_state_monitor.sv
// Passive checker for the 4-state ring sequencer: counts visits and laps, flags illegal jumps and stalls.
// Optional stall detection is enabled by defining FSM_STATE_MON_STALL_EN.
module fsm_state_monitor #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned DWELL_MAX = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           state_in,
    input  logic                 clear,
    output logic                 trans_valid,
    output logic [1:0]           trans_to,
    output logic [4*CNT_W-1:0]   visit_cnt,
    output logic [CNT_W-1:0]     lap_cnt,
    output logic                 err_illegal,
    output logic                 err_stall,
    output logic [1:0]           mon_state
);

    typedef enum logic [1:0] {
        MON_IDLE  = 2'b00,
        MON_TRACK = 2'b01,
        MON_FAULT = 2'b10
    } mon_e;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [7:0]       DWELL_SAT = 8'hFF;

    // Reject parameter values outside the supported range at elaboration
    if (CNT_W < 1 || DWELL_MAX < 2 || DWELL_MAX > 255) begin : g_bad_param
        $error("fsm_state_monitor: CNT_W must be >= 1 and DWELL_MAX in 2..255");
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    mon_e             mode_q, mode_d;
    logic [1:0]       prev_q, prev_d;
    logic             trans_valid_q, trans_valid_d;
    logic [1:0]       trans_to_q, trans_to_d;
    logic [CNT_W-1:0] visit_q [4];
    logic [CNT_W-1:0] visit_d [4];
    logic [CNT_W-1:0] lap_q, lap_d;
    logic             err_illegal_q, err_illegal_d;
`ifdef FSM_STATE_MON_STALL_EN
    logic [7:0]       dwell_q, dwell_d;
    logic             err_stall_q, err_stall_d;
`endif

    // Next-state and output computation; clear overrides the sample
    always_comb begin
        mode_d        = mode_q;
        prev_d        = prev_q;
        trans_valid_d = 1'b0;
        trans_to_d    = trans_to_q;
        for (int i = 0; i < 4; i++) visit_d[i] = visit_q[i];
        lap_d         = lap_q;
        err_illegal_d = err_illegal_q;
`ifdef FSM_STATE_MON_STALL_EN
        dwell_d       = dwell_q;
        err_stall_d   = err_stall_q;
`endif
        if (clear) begin
            mode_d        = MON_IDLE;
            prev_d        = 2'b00;
            trans_to_d    = 2'b00;
            for (int i = 0; i < 4; i++) visit_d[i] = '0;
            lap_d         = '0;
            err_illegal_d = 1'b0;
`ifdef FSM_STATE_MON_STALL_EN
            dwell_d       = 8'd0;
            err_stall_d   = 1'b0;
`endif
        end else begin
            unique case (mode_q)
                MON_IDLE: begin
                    prev_d            = state_in;
                    visit_d[state_in] = CNT_W'(1);
                    mode_d            = MON_TRACK;
`ifdef FSM_STATE_MON_STALL_EN
                    dwell_d           = 8'd1;
`endif
                end
                MON_TRACK: begin
                    if (state_in == prev_q) begin
`ifdef FSM_STATE_MON_STALL_EN
                        dwell_d = (dwell_q == DWELL_SAT) ? dwell_q : dwell_q + 8'd1;
                        if (dwell_d == 8'(DWELL_MAX)) err_stall_d = 1'b1;
`endif
                    end else if (state_in == 2'(prev_q + 2'd1)) begin
                        prev_d            = state_in;
                        trans_valid_d     = 1'b1;
                        trans_to_d        = state_in;
                        visit_d[state_in] = sat_inc(visit_q[state_in]);
                        if (state_in == 2'b00) lap_d = sat_inc(lap_q);
`ifdef FSM_STATE_MON_STALL_EN
                        dwell_d           = 8'd1;
`endif
                    end else begin
                        prev_d        = state_in;
                        err_illegal_d = 1'b1;
                        mode_d        = MON_FAULT;
                    end
                end
                MON_FAULT: begin
                    prev_d = state_in;
                end
                default: begin
                    mode_d = MON_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q        <= MON_IDLE;
            prev_q        <= 2'b00;
            trans_valid_q <= 1'b0;
            trans_to_q    <= 2'b00;
            for (int i = 0; i < 4; i++) visit_q[i] <= '0;
            lap_q         <= '0;
            err_illegal_q <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            prev_q        <= prev_d;
            trans_valid_q <= trans_valid_d;
            trans_to_q    <= trans_to_d;
            for (int i = 0; i < 4; i++) visit_q[i] <= visit_d[i];
            lap_q         <= lap_d;
            err_illegal_q <= err_illegal_d;
        end
    end

`ifdef FSM_STATE_MON_STALL_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dwell_q     <= 8'd0;
            err_stall_q <= 1'b0;
        end else begin
            dwell_q     <= dwell_d;
            err_stall_q <= err_stall_d;
        end
    end

    assign err_stall = err_stall_q;
`else
    assign err_stall = 1'b0;
`endif

    assign trans_valid = trans_valid_q;
    assign trans_to    = trans_to_q;
    assign visit_cnt   = {visit_q[3], visit_q[2], visit_q[1], visit_q[0]};
    assign lap_cnt     = lap_q;
    assign err_illegal = err_illegal_q;
    assign mon_state   = mode_q;

endmodule

// File: tb/tb_fsm_state_monitor.sv
// Directed bench for fsm_state_monitor; a second instance with CNT_W=2 exercises saturation.
module tb_fsm_state_monitor;

    localparam int unsigned CNT_W = 16;
`ifdef FSM_STATE_MON_STALL_EN
    localparam logic STALL_ON = 1'b1;
`else
    localparam logic STALL_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic [1:0]        state_in;
    logic              clear;
    logic              trans_valid;
    logic [1:0]        trans_to;
    logic [4*CNT_W-1:0] visit_cnt;
    logic [CNT_W-1:0]  lap_cnt;
    logic              err_illegal, err_stall;
    logic [1:0]        mon_state;

    logic [1:0]        state_in2;
    logic              clear2;
    logic              trans_valid2;
    logic [1:0]        trans_to2;
    logic [7:0]        visit_cnt2;
    logic [1:0]        lap_cnt2;
    logic              err_illegal2, err_stall2;
    logic [1:0]        mon_state2;

    int nvec = 0;
    int nerr = 0;
    int pulses;

    always #5 clk = ~clk;

    fsm_state_monitor #(.CNT_W(CNT_W), .DWELL_MAX(8)) dut (
        .clk(clk), .reset(reset_n), .state_in(state_in), .clear(clear),
        .trans_valid(trans_valid), .trans_to(trans_to), .visit_cnt(visit_cnt),
        .lap_cnt(lap_cnt), .err_illegal(err_illegal), .err_stall(err_stall),
        .mon_state(mon_state)
    );

    fsm_state_monitor #(.CNT_W(2), .DWELL_MAX(8)) dut2 (
        .clk(clk), .reset(reset_n), .state_in(state_in2), .clear(clear2),
        .trans_valid(trans_valid2), .trans_to(trans_to2), .visit_cnt(visit_cnt2),
        .lap_cnt(lap_cnt2), .err_illegal(err_illegal2), .err_stall(err_stall2),
        .mon_state(mon_state2)
    );

    task automatic apply(input logic [1:0] s);
        state_in = s;
        @(posedge clk);
        #1;
        if (trans_valid) pulses++;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; clear = 1'b0; state_in = 2'b00; clear2 = 1'b0; state_in2 = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        nvec++;
        if ({trans_valid, trans_to, err_illegal, err_stall, mon_state} !== 7'd0) begin
            nerr++; $display("FAIL reset_flags: got %b required 0", {trans_valid, trans_to, err_illegal, err_stall, mon_state});
        end
        nvec++;
        if (visit_cnt !== '0 || lap_cnt !== '0) begin
            nerr++; $display("FAIL reset_counters: got visit=%h lap=%h required 0", visit_cnt, lap_cnt);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_laps();
        logic [1:0] seq [13] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_clear();
        pulses = 0;
        for (int i = 0; i < 13; i++) begin
            apply(seq[i]);
            if (i == 0) begin
                nvec++;
                if (trans_valid !== 1'b0 || mon_state !== 2'b01) begin
                    nerr++; $display("FAIL laps_first: got tv=%b mon=%b required tv=0 mon=01", trans_valid, mon_state);
                end
            end
            if (i == 2) begin
                nvec++;
                if (trans_valid !== 1'b1 || trans_to !== 2'b10) begin
                    nerr++; $display("FAIL laps_trans: got tv=%b to=%b required tv=1 to=10", trans_valid, trans_to);
                end
            end
        end
        nvec++;
        if (visit_cnt !== {16'd3, 16'd3, 16'd3, 16'd4}) begin
            nerr++; $display("FAIL laps_visits: got %h required 0003000300030004", visit_cnt);
        end
        nvec++;
        if (lap_cnt !== 16'd3) begin
            nerr++; $display("FAIL laps_lap: got %0d required 3", lap_cnt);
        end
        nvec++;
        if (pulses != 12) begin
            nerr++; $display("FAIL laps_pulses: got %0d required 12", pulses);
        end
        nvec++;
        if (err_illegal !== 1'b0 || err_stall !== 1'b0 || mon_state !== 2'b01) begin
            nerr++; $display("FAIL laps_state: got ill=%b stall=%b mon=%b required 0 0 01", err_illegal, err_stall, mon_state);
        end
    endtask

    task automatic test_illegal();
        do_clear();
        apply(2'd0);
        apply(2'd1);
        apply(2'd3);
        nvec++;
        if (err_illegal !== 1'b1 || mon_state !== 2'b10) begin
            nerr++; $display("FAIL illegal_flag: got ill=%b mon=%b required 1 10", err_illegal, mon_state);
        end
        nvec++;
        if (visit_cnt[3*CNT_W +: CNT_W] !== 16'd0 || trans_valid !== 1'b0) begin
            nerr++; $display("FAIL illegal_v3: got v3=%0d tv=%b required 0 0", visit_cnt[3*CNT_W +: CNT_W], trans_valid);
        end
        apply(2'd0);
        nvec++;
        if (lap_cnt !== 16'd0 || trans_valid !== 1'b0 || visit_cnt[CNT_W-1:0] !== 16'd1) begin
            nerr++; $display("FAIL illegal_frozen: got lap=%0d tv=%b v0=%0d required 0 0 1", lap_cnt, trans_valid, visit_cnt[CNT_W-1:0]);
        end
        nvec++;
        if (err_illegal !== 1'b1 || mon_state !== 2'b10) begin
            nerr++; $display("FAIL illegal_sticky: got ill=%b mon=%b required 1 10", err_illegal, mon_state);
        end
    endtask

    task automatic test_stall();
        do_clear();
        apply(2'd0);
        apply(2'd1);
        for (int i = 0; i < 8; i++) begin
            apply(2'd2);
            if (i == 6) begin
                nvec++;
                if (err_stall !== 1'b0) begin
                    nerr++; $display("FAIL stall_early: got %b required 0", err_stall);
                end
            end
        end
        nvec++;
        if (err_stall !== STALL_ON || mon_state !== 2'b01 || err_illegal !== 1'b0) begin
            nerr++; $display("FAIL stall_fire: got stall=%b mon=%b ill=%b required %b 01 0", err_stall, mon_state, err_illegal, STALL_ON);
        end
        apply(2'd3);
        nvec++;
        if (err_stall !== STALL_ON || trans_valid !== 1'b1 || trans_to !== 2'b11) begin
            nerr++; $display("FAIL stall_continue: got stall=%b tv=%b to=%b required %b 1 11", err_stall, trans_valid, trans_to, STALL_ON);
        end
    endtask

    task automatic test_clear_collision();
        do_clear();
        apply(2'd0);
        apply(2'd1);
        clear = 1'b1;
        apply(2'd2);
        clear = 1'b0;
        nvec++;
        if (trans_valid !== 1'b0 || mon_state !== 2'b00) begin
            nerr++; $display("FAIL clear_pulse: got tv=%b mon=%b required 0 00", trans_valid, mon_state);
        end
        nvec++;
        if (visit_cnt !== '0 || lap_cnt !== '0 || trans_to !== 2'b00) begin
            nerr++; $display("FAIL clear_counters: got visit=%h lap=%h to=%b required 0", visit_cnt, lap_cnt, trans_to);
        end
        apply(2'd3);
        nvec++;
        if (visit_cnt !== {16'd1, 16'd0, 16'd0, 16'd0} || mon_state !== 2'b01 || trans_valid !== 1'b0) begin
            nerr++; $display("FAIL clear_next: got visit=%h mon=%b tv=%b required 0001000000000000 01 0", visit_cnt, mon_state, trans_valid);
        end
    endtask

    task automatic test_async_reset();
        do_clear();
        apply(2'd0);
        apply(2'd1);
        #2;
        reset_n = 1'b0;
        #1;
        nvec++;
        if ({trans_valid, trans_to, err_illegal, err_stall, mon_state} !== 7'd0 || visit_cnt !== '0 || lap_cnt !== '0) begin
            nerr++; $display("FAIL async_reset: got flags=%b visit=%h lap=%h required 0",
                             {trans_valid, trans_to, err_illegal, err_stall, mon_state}, visit_cnt, lap_cnt);
        end
        @(negedge clk);
        reset_n = 1'b1;
        apply(2'd2);
        nvec++;
        if (err_illegal !== 1'b0 || mon_state !== 2'b01 || visit_cnt !== {16'd0, 16'd1, 16'd0, 16'd0}) begin
            nerr++; $display("FAIL reset_first: got ill=%b mon=%b visit=%h required 0 01 0000000100000000", err_illegal, mon_state, visit_cnt);
        end
        apply(2'd3);
        nvec++;
        if (trans_valid !== 1'b1 || trans_to !== 2'b11) begin
            nerr++; $display("FAIL reset_resume: got tv=%b to=%b required 1 11", trans_valid, trans_to);
        end
    endtask

    task automatic test_saturation();
        clear2 = 1'b1;
        @(posedge clk);
        #1;
        clear2 = 1'b0;
        for (int i = 0; i < 21; i++) begin
            state_in2 = 2'(i);
            @(posedge clk);
            #1;
        end
        nvec++;
        if (lap_cnt2 !== 2'd3) begin
            nerr++; $display("FAIL sat_lap: got %0d required 3", lap_cnt2);
        end
        nvec++;
        if (visit_cnt2 !== 8'hFF) begin
            nerr++; $display("FAIL sat_visits: got %h required ff", visit_cnt2);
        end
        nvec++;
        if (err_illegal2 !== 1'b0 || mon_state2 !== 2'b01) begin
            nerr++; $display("FAIL sat_state: got ill=%b mon=%b required 0 01", err_illegal2, mon_state2);
        end
    endtask

    initial begin
        test_reset();
        test_laps();
        test_illegal();
        test_stall();
        test_clear_collision();
        test_async_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
